// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX operand stage.
//   alu_op_e  : alu opcode encodings
//   fwd_sel_e : per-operand forwarding source
//   id_ex_t   : registered control fields of the ID/EX slot
// The data words and register indices are parameterized, so they live
// beside the struct in the stage rather than inside it.
package pipe_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_EQ  = 4'b1000,
        ALU_NE  = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_SLT = 4'b1100,
        ALU_GE  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic            alu_src;
        logic [OP_W-1:0] operation;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the source of one alu operand from the registered source index.
// EX/MEM has priority over MEM/WB because it holds the younger result.
// x0 is never forwarded.
// Ports:
//   rs            registered source index
//   mem_rd        EX/MEM destination, mem_reg_write its write enable
//   wb_rd         MEM/WB destination, wb_reg_write its write enable
//   sel           FWD_MEM / FWD_WB / FWD_REG
module forwarding_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] rs,
    input  logic [REG_ADDR-1:0] mem_rd,
    input  logic                mem_reg_write,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic                wb_reg_write,
    output fwd_sel_e            sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
            sel = FWD_MEM;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and alu operand select.
// Registers the decoded instruction, forwards EX/MEM and MEM/WB results onto
// the operands, detects load-use hazards (inserting a bubble), and passes
// EX-side control on toward EX/MEM.
// Build option: define ALU_FWD_EN to enable operand forwarding. Without it
// the operands come straight from the register and the hazard check widens
// to every RAW against EX and MEM.
// Ports:
//   clk, reset                 clock, async active-high reset
//   Stall, Flush               hold / bubble controls (Flush wins)
//   Id*                        decoded instruction from ID
//   MemRd/MemRegWrite/MemALUResult   EX/MEM writeback candidate
//   WbRd/WbRegWrite/WbData           MEM/WB writeback candidate
//   SrcA, SrcB, Operation      alu inputs
//   ExStoreData                forwarded rs2 for stores
//   ExValid/ExRegWrite/ExMemRead/ExMemWrite/ExRd/ExPC  EX-side control
//   LoadUseHazard              upstream must hold PC and IF/ID
module id_ex_operand_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Stall,
    input  logic                     Flush,
    input  logic                     IdValid,
    input  logic [31:0]              IdPC,
    input  logic [DATA_WIDTH-1:0]    IdRs1Data,
    input  logic [DATA_WIDTH-1:0]    IdRs2Data,
    input  logic [DATA_WIDTH-1:0]    IdImm,
    input  logic [REG_ADDR-1:0]      IdRs1,
    input  logic [REG_ADDR-1:0]      IdRs2,
    input  logic [REG_ADDR-1:0]      IdRd,
    input  logic                     IdALUSrc,
    input  logic [OPCODE_LENGTH-1:0] IdOperation,
    input  logic                     IdRegWrite,
    input  logic                     IdMemRead,
    input  logic                     IdMemWrite,
    input  logic [REG_ADDR-1:0]      MemRd,
    input  logic                     MemRegWrite,
    input  logic [DATA_WIDTH-1:0]    MemALUResult,
    input  logic [REG_ADDR-1:0]      WbRd,
    input  logic                     WbRegWrite,
    input  logic [DATA_WIDTH-1:0]    WbData,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ExStoreData,
    output logic                     ExValid,
    output logic                     ExRegWrite,
    output logic                     ExMemRead,
    output logic                     ExMemWrite,
    output logic [REG_ADDR-1:0]      ExRd,
    output logic [31:0]              ExPC,
    output logic                     LoadUseHazard
);

    // Registered slot
    id_ex_t                ctl;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data, imm;
    logic [REG_ADDR-1:0]   rs1, rs2, rd;

    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
    logic                  hazard;

    // WB writes landing on a held source while stalled; without this the
    // held operand would go stale once the writer leaves WB.
    logic wb_hit_rs1, wb_hit_rs2;
    assign wb_hit_rs1 = WbRegWrite && (WbRd != '0) && (WbRd == rs1);
    assign wb_hit_rs2 = WbRegWrite && (WbRd != '0) && (WbRd == rs2);

    // ID sources matching a nonzero destination
    logic ex_raw, mem_raw;
    assign ex_raw  = (ctl.valid) && (rd != '0) && ((rd == IdRs1) || (rd == IdRs2));
    assign mem_raw = (MemRd != '0) && ((MemRd == IdRs1) || (MemRd == IdRs2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl      <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm      <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
        end else if (Flush) begin
            ctl.valid     <= 1'b0;
            ctl.reg_write <= 1'b0;
            ctl.mem_read  <= 1'b0;
            ctl.mem_write <= 1'b0;
        end else if (Stall) begin
            if (wb_hit_rs1) rs1_data <= WbData;
            if (wb_hit_rs2) rs2_data <= WbData;
        end else if (hazard) begin
            // Bubble; the ID instruction is re-presented next cycle.
            ctl.valid     <= 1'b0;
            ctl.reg_write <= 1'b0;
            ctl.mem_read  <= 1'b0;
            ctl.mem_write <= 1'b0;
        end else begin
            ctl.valid     <= IdValid;
            ctl.pc        <= IdPC;
            ctl.alu_src   <= IdALUSrc;
            ctl.operation <= OP_W'(IdOperation);
            ctl.reg_write <= IdRegWrite;
            ctl.mem_read  <= IdMemRead;
            ctl.mem_write <= IdMemWrite;
            rs1_data      <= IdRs1Data;
            rs2_data      <= IdRs2Data;
            imm           <= IdImm;
            rs1           <= IdRs1;
            rs2           <= IdRs2;
            rd            <= IdRd;
        end
    end

`ifdef ALU_FWD_EN
    fwd_sel_e sel_a, sel_b;

    forwarding_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs1 (
        .rs            (rs1),
        .mem_rd        (MemRd),
        .mem_reg_write (MemRegWrite),
        .wb_rd         (WbRd),
        .wb_reg_write  (WbRegWrite),
        .sel           (sel_a)
    );

    forwarding_unit #(.REG_ADDR(REG_ADDR)) u_fwd_rs2 (
        .rs            (rs2),
        .mem_rd        (MemRd),
        .mem_reg_write (MemRegWrite),
        .wb_rd         (WbRd),
        .wb_reg_write  (WbRegWrite),
        .sel           (sel_b)
    );

    always_comb begin
        case (sel_a)
            FWD_MEM: fwd_rs1 = MemALUResult;
            FWD_WB:  fwd_rs1 = WbData;
            default: fwd_rs1 = rs1_data;
        endcase
        case (sel_b)
            FWD_MEM: fwd_rs2 = MemALUResult;
            FWD_WB:  fwd_rs2 = WbData;
            default: fwd_rs2 = rs2_data;
        endcase
    end

    // Only a load in EX cannot be covered by forwarding.
    assign hazard = IdValid && ctl.mem_read && ex_raw;

    logic unused_mem_raw;
    assign unused_mem_raw = mem_raw;
`else
    assign fwd_rs1 = rs1_data;
    assign fwd_rs2 = rs2_data;

    // Any producer still in EX or MEM must drain to WB, where register-file
    // write-first (and the stall refresh) supply the value.
    assign hazard = IdValid && ((ctl.reg_write && ex_raw) || (MemRegWrite && mem_raw));

    logic unused_mem_result;
    assign unused_mem_result = ^MemALUResult;
`endif

    assign SrcA          = fwd_rs1;
    assign SrcB          = ctl.alu_src ? imm : fwd_rs2;
    assign ExStoreData   = fwd_rs2;
    assign Operation     = OPCODE_LENGTH'(ctl.operation);
    assign ExValid       = ctl.valid;
    assign ExRegWrite    = ctl.reg_write;
    assign ExMemRead     = ctl.mem_read;
    assign ExMemWrite    = ctl.mem_write;
    assign ExRd          = rd;
    assign ExPC          = ctl.pc;
    assign LoadUseHazard = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow ALU_FWD_EN.
module tb_id_ex_operand_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush, IdValid;
    logic [31:0] IdPC, IdRs1Data, IdRs2Data, IdImm;
    logic [4:0]  IdRs1, IdRs2, IdRd;
    logic        IdALUSrc;
    logic [3:0]  IdOperation;
    logic        IdRegWrite, IdMemRead, IdMemWrite;
    logic [4:0]  MemRd;
    logic        MemRegWrite;
    logic [31:0] MemALUResult;
    logic [4:0]  WbRd;
    logic        WbRegWrite;
    logic [31:0] WbData;
    logic [31:0] SrcA, SrcB, ExStoreData, ExPC;
    logic [3:0]  Operation;
    logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, LoadUseHazard;
    logic [4:0]  ExRd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .IdValid(IdValid), .IdPC(IdPC), .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data),
        .IdImm(IdImm), .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRd(IdRd), .IdALUSrc(IdALUSrc),
        .IdOperation(IdOperation), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .MemRd(MemRd), .MemRegWrite(MemRegWrite),
        .MemALUResult(MemALUResult), .WbRd(WbRd), .WbRegWrite(WbRegWrite), .WbData(WbData),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ExStoreData(ExStoreData),
        .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExMemWrite(ExMemWrite), .ExRd(ExRd), .ExPC(ExPC), .LoadUseHazard(LoadUseHazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] d, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] im, input logic asrc,
                          input logic [3:0] op, input logic rw, input logic mr, input logic mw);
        IdValid = v; IdPC = pc; IdRs1 = r1; IdRs2 = r2; IdRd = d;
        IdRs1Data = d1; IdRs2Data = d2; IdImm = im; IdALUSrc = asrc;
        IdOperation = op; IdRegWrite = rw; IdMemRead = mr; IdMemWrite = mw;
    endtask

    task automatic mem_set(input logic [4:0] d, input logic w, input logic [31:0] r);
        MemRd = d; MemRegWrite = w; MemALUResult = r;
    endtask

    task automatic wb_set(input logic [4:0] d, input logic w, input logic [31:0] r);
        WbRd = d; WbRegWrite = w; WbData = r;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        mem_set(0, 0, 0);
        wb_set(0, 0, 0);

        // Reset state
        #2;
        chk("rst_valid", ExValid, 0);
        chk("rst_op", Operation, 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_pc", ExPC, 0);
        @(negedge clk);
        reset = 1'b0;

        // Mid-stream async reset
        set_id(1, 32'h100, 1, 2, 3, 32'h111, 32'h222, 0, 0, ALU_ADD, 1, 0, 0);
        tick();
        chk("pre_rst_valid", ExValid, 1);
        mem_set(1, 1, 32'h10);
        IdValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", ExValid, 0);
        chk("mid_rst_op", Operation, 0);
        chk("mid_rst_srca", SrcA, 0);
        chk("mid_rst_srcb", SrcB, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_set(0, 0, 0);

        // ADD r3,r1,r2 with MEM feeding r1 and WB feeding r2
        set_id(1, 32'h104, 1, 2, 3, 32'h111, 32'h222, 0, 0, ALU_ADD, 1, 0, 0);
        tick();
        mem_set(1, 1, 32'h10);
        wb_set(2, 1, 32'h20);
        IdValid = 1'b0;
        #1;
`ifdef ALU_FWD_EN
        chk("add_srca", SrcA, 32'h10);
        chk("add_srcb", SrcB, 32'h20);
        chk("add_store", ExStoreData, 32'h20);
`else
        chk("add_srca", SrcA, 32'h111);
        chk("add_srcb", SrcB, 32'h222);
        chk("add_store", ExStoreData, 32'h222);
`endif
        chk("add_op", Operation, 4'b0010);
        chk("add_rd", ExRd, 3);
        chk("add_pc", ExPC, 32'h104);
        chk("add_rw", ExRegWrite, 1);

        // MEM beats WB on the same source; imm selected for SrcB
        mem_set(0, 0, 0); wb_set(0, 0, 0);
        set_id(1, 32'h108, 5, 0, 6, 32'h555, 32'h66, 32'h44, 1, ALU_ADD, 1, 0, 0);
        tick();
        mem_set(5, 1, 32'hAAA);
        wb_set(5, 1, 32'hBBB);
        IdValid = 1'b0;
        #1;
`ifdef ALU_FWD_EN
        chk("prio_srca", SrcA, 32'hAAA);
`else
        chk("prio_srca", SrcA, 32'h555);
`endif
        chk("imm_srcb", SrcB, 32'h44);
        chk("x0_store", ExStoreData, 32'h66);

        // x0 never forwarded
        mem_set(0, 0, 0); wb_set(0, 0, 0);
        set_id(1, 32'h10C, 0, 0, 0, 32'h777, 32'h88, 0, 0, ALU_OR, 0, 0, 0);
        tick();
        mem_set(0, 1, 32'h999);
        wb_set(0, 1, 32'hBBB);
        IdValid = 1'b0;
        #1;
        chk("x0_srca", SrcA, 32'h777);
        chk("x0_srcb", SrcB, 32'h88);
        chk("or_op", Operation, 4'b0001);

        // Load-use: lw x7 then add x8,x0,x7
        mem_set(0, 0, 0); wb_set(0, 0, 0);
        set_id(1, 32'h110, 0, 0, 7, 0, 0, 32'h4, 1, ALU_ADD, 1, 1, 0);
        tick();
        chk("lw_memread", ExMemRead, 1);
        set_id(1, 32'h114, 0, 7, 8, 0, 32'h70, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        chk("lu_hazard", LoadUseHazard, 1);
        tick();
        chk("lu_bubble_valid", ExValid, 0);
        chk("lu_bubble_rw", ExRegWrite, 0);
        mem_set(7, 1, 32'h1000);
        #1;
`ifdef ALU_FWD_EN
        chk("lu_mem_hazard", LoadUseHazard, 0);
        tick();
        chk("lu_load_valid", ExValid, 1);
        chk("lu_load_rd", ExRd, 8);
        mem_set(0, 0, 0);
        wb_set(7, 1, 32'hDEAD);
        IdValid = 1'b0;
        #1;
        chk("lu_wb_srcb", SrcB, 32'hDEAD);
        chk("lu_wb_store", ExStoreData, 32'hDEAD);
`else
        chk("lu_mem_hazard", LoadUseHazard, 1);
        tick();
        chk("lu_bubble2_valid", ExValid, 0);
        mem_set(0, 0, 0);
        wb_set(7, 1, 32'hDEAD);
        IdRs2Data = 32'hDEAD;
        #1;
        chk("lu_wb_hazard", LoadUseHazard, 0);
        tick();
        wb_set(0, 0, 0);
        IdValid = 1'b0;
        #1;
        chk("lu_load_valid", ExValid, 1);
        chk("lu_load_rd", ExRd, 8);
        chk("lu_wb_srcb", SrcB, 32'hDEAD);
`endif

        // Stall 3 cycles, WB refreshes held rs1
        mem_set(0, 0, 0); wb_set(0, 0, 0);
        set_id(1, 32'h300, 9, 10, 11, 32'h1, 32'h2, 0, 0, ALU_SUB, 1, 0, 0);
        tick();
        Stall = 1'b1;
        set_id(1, 32'h400, 12, 13, 14, 32'h5, 32'h6, 32'h7, 1, ALU_XOR, 0, 1, 1);
        wb_set(9, 1, 32'hABCD);
        tick();
        wb_set(0, 0, 0);
        tick();
        tick();
        chk("stall_srca", SrcA, 32'hABCD);
        chk("stall_srcb", SrcB, 32'h2);
        chk("stall_op", Operation, 4'b0110);
        chk("stall_pc", ExPC, 32'h300);
        chk("stall_rd", ExRd, 11);
        chk("stall_valid", ExValid, 1);
        chk("stall_memread", ExMemRead, 0);

        // Flush with Stall: flush wins, SW becomes a bubble
        Flush = 1'b1;
        set_id(1, 32'h500, 0, 0, 0, 32'h0, 32'h123, 32'h8, 1, ALU_ADD, 0, 0, 1);
        tick();
        chk("flush_valid", ExValid, 0);
        chk("flush_memwrite", ExMemWrite, 0);
        chk("flush_rw", ExRegWrite, 0);

        // Same SW loads normally once released
        Flush = 1'b0; Stall = 1'b0;
        tick();
        chk("sw_valid", ExValid, 1);
        chk("sw_memwrite", ExMemWrite, 1);
        chk("sw_store", ExStoreData, 32'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
